// File: rtl/pipe_hazard_ctrl_if.sv
// Stage-field and control bundle between the Y86-64 datapath and the hazard controller.
// The datapath side is the master; the controller is the slave.
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [3:0]       D_icode;
    logic [3:0]       d_srcA;
    logic [3:0]       d_srcB;
    logic [3:0]       E_icode;
    logic [3:0]       E_ifun;
    logic [3:0]       E_destM;
    logic             e_zf;
    logic             e_sf;
    logic             e_of;
    logic [3:0]       M_icode;
    logic [3:0]       m_stat;
    logic [3:0]       W_icode;
    logic [3:0]       W_stat;

    logic             cc_zf;
    logic             cc_sf;
    logic             cc_of;
    logic             cc_cond;
    logic             set_cc;
    logic             F_stall;
    logic             D_stall;
    logic             W_stall;
    logic             D_bubble;
    logic             E_bubble;
    logic             M_bubble;
    logic             halted;
    logic [3:0]       halt_stat;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] retire_cnt;

    modport master (
        output D_icode, d_srcA, d_srcB, E_icode, E_ifun, E_destM,
               e_zf, e_sf, e_of, M_icode, m_stat, W_icode, W_stat,
        input  cc_zf, cc_sf, cc_of, cc_cond, set_cc,
               F_stall, D_stall, W_stall, D_bubble, E_bubble, M_bubble,
               halted, halt_stat, cycle_cnt, retire_cnt
    );

    modport slave (
        input  D_icode, d_srcA, d_srcB, E_icode, E_ifun, E_destM,
               e_zf, e_sf, e_of, M_icode, m_stat, W_icode, W_stat,
        output cc_zf, cc_sf, cc_of, cc_cond, set_cc,
               F_stall, D_stall, W_stall, D_bubble, E_bubble, M_bubble,
               halted, halt_stat, cycle_cnt, retire_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Central pipeline control for the five-stage Y86-64 core: condition codes, hazard
// stall/bubble generation, halt-on-exception state machine and cycle/retire counters.
module pipe_hazard_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    pipe_hazard_ctrl_if.slave bus
);
    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_POPQ   = 4'hB;
    localparam logic [3:0] S_AOK    = 4'h1;
    localparam logic [3:0] R_NONE   = 4'hF;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t           state;
    logic             zf;
    logic             sf;
    logic             of;
    logic [3:0]       halt_stat_q;
    logic [CNT_W-1:0] cycle_q;
    logic [CNT_W-1:0] retire_q;

    logic cond;
    logic load_use;
    logic ret_busy;
    logic mispred;
    logic exc_mw;
    logic set_cc;
    logic f_stall;
    logic d_stall;
    logic w_stall;
    logic d_bubble;
    logic e_bubble;
    logic m_bubble;

    // Branch/cmov condition always comes from the committed CC, never the in-flight ALU flags.
    always_comb begin
        cond = 1'b0;
        case (bus.E_ifun)
            4'h0:    cond = 1'b1;
            4'h1:    cond = (sf ^ of) | zf;
            4'h2:    cond = sf ^ of;
            4'h3:    cond = zf;
            4'h4:    cond = ~zf;
            4'h5:    cond = ~(sf ^ of);
            4'h6:    cond = ~(sf ^ of) & ~zf;
            default: cond = 1'b0;
        endcase
    end

    always_comb begin
        load_use = ((bus.E_icode == I_MRMOVQ) || (bus.E_icode == I_POPQ)) &&
                   (bus.E_destM != R_NONE) &&
                   ((bus.E_destM == bus.d_srcA) || (bus.E_destM == bus.d_srcB));
        ret_busy = (bus.D_icode == I_RET) || (bus.E_icode == I_RET) || (bus.M_icode == I_RET);
        mispred  = (bus.E_icode == I_JXX) && !cond;
        exc_mw   = (bus.m_stat != S_AOK) || (bus.W_stat != S_AOK);
    end

    // Reset flushes every stage; HALTED freezes everything; otherwise resolve hazards.
    // Load-use wins over ret in decode so the stalled instruction is not lost.
    always_comb begin
        f_stall  = 1'b0;
        d_stall  = 1'b0;
        w_stall  = 1'b0;
        d_bubble = 1'b0;
        e_bubble = 1'b0;
        m_bubble = 1'b0;
        set_cc   = 1'b0;
        if (!rst_n) begin
            d_bubble = 1'b1;
            e_bubble = 1'b1;
            m_bubble = 1'b1;
        end else if (state == HALTED) begin
            f_stall = 1'b1;
            d_stall = 1'b1;
            w_stall = 1'b1;
        end else begin
            f_stall  = load_use | ret_busy;
            d_stall  = load_use;
            d_bubble = mispred | (ret_busy & ~load_use);
            e_bubble = mispred | load_use;
            set_cc   = (bus.E_icode == I_OPQ) & ~exc_mw;
            m_bubble = exc_mw;
            w_stall  = bus.W_stat != S_AOK;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= RUN;
            zf          <= 1'b1;
            sf          <= 1'b0;
            of          <= 1'b0;
            halt_stat_q <= S_AOK;
            cycle_q     <= '0;
            retire_q    <= '0;
        end else if (state == RUN) begin
            cycle_q <= cycle_q + 1'b1;
            if ((bus.W_stat == S_AOK) && (bus.W_icode != I_HALT) && (bus.W_icode != I_NOP)) begin
                retire_q <= retire_q + 1'b1;
            end
            if (set_cc) begin
                zf <= bus.e_zf;
                sf <= bus.e_sf;
                of <= bus.e_of;
            end
            if (bus.W_stat != S_AOK) begin
                state       <= HALTED;
                halt_stat_q <= bus.W_stat;
            end
        end
    end

    assign bus.cc_zf      = zf;
    assign bus.cc_sf      = sf;
    assign bus.cc_of      = of;
    assign bus.cc_cond    = cond;
    assign bus.set_cc     = set_cc;
    assign bus.F_stall    = f_stall;
    assign bus.D_stall    = d_stall;
    assign bus.W_stall    = w_stall;
    assign bus.D_bubble   = d_bubble;
    assign bus.E_bubble   = e_bubble;
    assign bus.M_bubble   = m_bubble;
    assign bus.halted     = state == HALTED;
    assign bus.halt_stat  = halt_stat_q;
    assign bus.cycle_cnt  = cycle_q;
    assign bus.retire_cnt = retire_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus randomized traffic
// compared against a rule-level model of CC, hazards, halt and counters.
module tb_pipe_hazard_ctrl;
    localparam int CNT_W = 4;
    localparam int CNT_MOD = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipe_hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Control vector order: {F_stall, D_stall, W_stall, D_bubble, E_bubble, M_bubble, set_cc}
    wire [6:0] ctl = {bus.F_stall, bus.D_stall, bus.W_stall, bus.D_bubble,
                      bus.E_bubble, bus.M_bubble, bus.set_cc};
    wire [2:0] ccv = {bus.cc_zf, bus.cc_sf, bus.cc_of};

    logic [2:0] m_cc = 3'b100;
    bit         m_halted = 1'b0;
    logic [3:0] m_hstat = 4'h1;
    int         m_cycles = 0;
    int         m_retired = 0;

    function automatic logic model_cond(input logic [3:0] ifun);
        bit z = m_cc[2];
        bit lt = (m_cc[1] != m_cc[0]);
        case (ifun)
            0: return 1'b1;
            1: return lt || z;
            2: return lt;
            3: return z;
            4: return !z;
            5: return !lt;
            6: return !lt && !z;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [6:0] model_ctl();
        bit lu, ret, mp, exc;
        if (!rst_n) return 7'b0001110;
        if (m_halted) return 7'b1110000;
        lu  = (bus.E_icode inside {4'h5, 4'hB}) && bus.E_destM != 4'hF &&
              (bus.E_destM == bus.d_srcA || bus.E_destM == bus.d_srcB);
        ret = bus.D_icode == 4'h9 || bus.E_icode == 4'h9 || bus.M_icode == 4'h9;
        mp  = bus.E_icode == 4'h7 && !model_cond(bus.E_ifun);
        exc = bus.m_stat != 4'h1 || bus.W_stat != 4'h1;
        return {lu || ret, lu, bus.W_stat != 4'h1, mp || (ret && !lu), mp || lu, exc,
                bus.E_icode == 4'h6 && !exc};
    endfunction

    task automatic set_quiet();
        bus.D_icode = 4'h1; bus.d_srcA = 4'hF; bus.d_srcB = 4'hF;
        bus.E_icode = 4'h1; bus.E_ifun = 4'h0; bus.E_destM = 4'hF;
        bus.e_zf = 1'b0; bus.e_sf = 1'b0; bus.e_of = 1'b0;
        bus.M_icode = 4'h1; bus.m_stat = 4'h1; bus.W_icode = 4'h1; bus.W_stat = 4'h1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Advance one clock edge and apply the same edge to the reference model.
    task automatic tick();
        logic [6:0] c = model_ctl();
        logic [2:0] flags = {bus.e_zf, bus.e_sf, bus.e_of};
        @(posedge clk);
        if (!rst_n) begin
            m_halted = 1'b0; m_cc = 3'b100; m_hstat = 4'h1; m_cycles = 0; m_retired = 0;
        end else if (!m_halted) begin
            m_cycles = (m_cycles + 1) % CNT_MOD;
            if (bus.W_stat == 4'h1 && !(bus.W_icode inside {4'h0, 4'h1}))
                m_retired = (m_retired + 1) % CNT_MOD;
            if (c[0]) m_cc = flags;
            if (bus.W_stat != 4'h1) begin
                m_halted = 1'b1;
                m_hstat = bus.W_stat;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        set_quiet();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        set_quiet();
        rst_n = 1'b0;
        settle();
        checks++;
        if (ctl !== 7'b0001110) begin
            errors++; $display("[TB] FAIL reset_ctl got %b want %b", ctl, 7'b0001110);
        end
        tick();
        rst_n = 1'b1;
        checks++;
        if ({ccv, bus.halted, bus.halt_stat} !== {3'b100, 1'b0, 4'h1}) begin
            errors++; $display("[TB] FAIL reset_state got cc=%b halted=%b hs=%h", ccv, bus.halted, bus.halt_stat);
        end
        checks++;
        if ({bus.cycle_cnt, bus.retire_cnt} !== 8'h00) begin
            errors++; $display("[TB] FAIL reset_cnt got %0d/%0d want 0/0", bus.cycle_cnt, bus.retire_cnt);
        end
    endtask

    task automatic test_cc_write();
        do_reset();
        bus.E_icode = 4'h6; bus.e_zf = 1'b0; bus.e_sf = 1'b1; bus.e_of = 1'b0;
        settle();
        checks++;
        if (ctl !== 7'b0000001) begin
            errors++; $display("[TB] FAIL cc_set got %b want %b", ctl, 7'b0000001);
        end
        tick();
        set_quiet();
        bus.E_ifun = 4'h2;
        settle();
        checks++;
        if (ccv !== 3'b010) begin
            errors++; $display("[TB] FAIL cc_value got %b want 010", ccv);
        end
        checks++;
        if (bus.cc_cond !== 1'b1) begin
            errors++; $display("[TB] FAIL cond_l got %b want 1", bus.cc_cond);
        end
        bus.E_ifun = 4'h6;
        settle();
        checks++;
        if (bus.cc_cond !== 1'b0) begin
            errors++; $display("[TB] FAIL cond_g got %b want 0", bus.cc_cond);
        end
    endtask

    task automatic test_load_use();
        set_quiet();
        bus.E_icode = 4'h5; bus.E_destM = 4'h3; bus.d_srcB = 4'h3;
        settle();
        checks++;
        if (ctl !== 7'b1100100) begin
            errors++; $display("[TB] FAIL load_use got %b want %b", ctl, 7'b1100100);
        end
        bus.E_destM = 4'hF;
        settle();
        checks++;
        if (ctl !== 7'b0000000) begin
            errors++; $display("[TB] FAIL load_none got %b want 0", ctl);
        end
        bus.E_icode = 4'hB; bus.E_destM = 4'h3; bus.D_icode = 4'h9;
        settle();
        checks++;
        if (ctl !== 7'b1100100) begin
            errors++; $display("[TB] FAIL load_ret got %b want %b", ctl, 7'b1100100);
        end
    endtask

    task automatic test_ret();
        logic [3:0] stage_icodes [4][3] = '{'{4'h9, 4'h1, 4'h1}, '{4'h1, 4'h9, 4'h1},
                                            '{4'h1, 4'h1, 4'h9}, '{4'h1, 4'h1, 4'h1}};
        logic [6:0] want;
        set_quiet();
        for (int i = 0; i < 4; i++) begin
            bus.D_icode = stage_icodes[i][0];
            bus.E_icode = stage_icodes[i][1];
            bus.M_icode = stage_icodes[i][2];
            bus.W_icode = (i == 3) ? 4'h9 : 4'h1;
            settle();
            want = (i == 3) ? 7'b0000000 : 7'b1001000;
            checks++;
            if (ctl !== want) begin
                errors++; $display("[TB] FAIL ret_stage%0d got %b want %b", i, ctl, want);
            end
            tick();
        end
    endtask

    task automatic test_mispredict();
        do_reset();
        bus.E_icode = 4'h6;
        tick();
        set_quiet();
        bus.E_icode = 4'h7; bus.E_ifun = 4'h3;
        settle();
        checks++;
        if (ctl !== 7'b0001100) begin
            errors++; $display("[TB] FAIL mispred got %b want %b", ctl, 7'b0001100);
        end
        bus.D_icode = 4'h9;
        settle();
        checks++;
        if (ctl !== 7'b1001100) begin
            errors++; $display("[TB] FAIL mispred_ret got %b want %b", ctl, 7'b1001100);
        end
        bus.D_icode = 4'h1;
        for (int f = 0; f < 5; f += 4) begin
            bus.E_ifun = 4'(f);
            settle();
            checks++;
            if (ctl !== 7'b0000000) begin
                errors++; $display("[TB] FAIL taken_ifun%0d got %b want 0", f, ctl);
            end
        end
    endtask

    task automatic test_halt();
        logic [2:0] cc_before;
        int cyc, ret;
        set_quiet();
        cc_before = m_cc;
        bus.E_icode = 4'h6; bus.e_zf = 1'b1; bus.e_sf = 1'b1; bus.e_of = 1'b1; bus.m_stat = 4'h3;
        settle();
        checks++;
        if (ctl !== 7'b0000010) begin
            errors++; $display("[TB] FAIL exc_m got %b want %b", ctl, 7'b0000010);
        end
        tick();
        checks++;
        if (ccv !== cc_before) begin
            errors++; $display("[TB] FAIL cc_held got %b want %b", ccv, cc_before);
        end
        set_quiet();
        bus.W_stat = 4'h3; bus.W_icode = 4'h6;
        settle();
        checks++;
        if (ctl !== 7'b0010010) begin
            errors++; $display("[TB] FAIL exc_w got %b want %b", ctl, 7'b0010010);
        end
        tick();
        cyc = m_cycles; ret = m_retired;
        checks++;
        if ({bus.halted, bus.halt_stat} !== {1'b1, 4'h3}) begin
            errors++; $display("[TB] FAIL halt_entry got %b/%h want 1/3", bus.halted, bus.halt_stat);
        end
        for (int i = 0; i < 3; i++) begin
            bus.E_icode = 4'h6; bus.e_zf = 1'($urandom); bus.W_stat = 4'h1; bus.D_icode = 4'h9;
            settle();
            checks++;
            if (ctl !== 7'b1110000) begin
                errors++; $display("[TB] FAIL halted_ctl got %b want %b", ctl, 7'b1110000);
            end
            tick();
            checks++;
            if (int'(bus.cycle_cnt) != cyc || int'(bus.retire_cnt) != ret || ccv !== cc_before) begin
                errors++; $display("[TB] FAIL halted_frozen got %0d/%0d cc=%b want %0d/%0d cc=%b",
                                   bus.cycle_cnt, bus.retire_cnt, ccv, cyc, ret, cc_before);
            end
        end
        do_reset();
        settle();
        checks++;
        if ({bus.halted, ccv, bus.cycle_cnt, bus.retire_cnt} !== {1'b0, 3'b100, 8'h00}) begin
            errors++; $display("[TB] FAIL halt_reset got h=%b cc=%b cnt=%0d/%0d want 0 100 0/0",
                               bus.halted, ccv, bus.cycle_cnt, bus.retire_cnt);
        end
    endtask

    task automatic test_counter_wrap();
        do_reset();
        bus.W_icode = 4'h6;
        for (int i = 0; i < 20; i++) tick();
        checks++;
        if ({bus.cycle_cnt, bus.retire_cnt} !== {4'd4, 4'd4}) begin
            errors++; $display("[TB] FAIL cnt_wrap got %0d/%0d want 4/4", bus.cycle_cnt, bus.retire_cnt);
        end
        bus.W_icode = 4'h1;
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if ({bus.cycle_cnt, bus.retire_cnt} !== {4'd7, 4'd4}) begin
            errors++; $display("[TB] FAIL cnt_nop got %0d/%0d want 7/4", bus.cycle_cnt, bus.retire_cnt);
        end
    endtask

    function automatic logic [3:0] rand_icode();
        logic [3:0] pool [8] = '{4'h0, 4'h1, 4'h5, 4'h6, 4'h7, 4'h9, 4'hB, 4'h2};
        return pool[$urandom_range(0, 7)];
    endfunction

    function automatic logic [3:0] rand_reg();
        return ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 3));
    endfunction

    task automatic test_random();
        logic [6:0] want;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            rst_n = ($urandom_range(0, m_halted ? 6 : 60) != 0);
            bus.D_icode = rand_icode(); bus.E_icode = rand_icode(); bus.M_icode = rand_icode();
            bus.W_icode = rand_icode(); bus.E_ifun = 4'($urandom_range(0, 8));
            bus.d_srcA = rand_reg(); bus.d_srcB = rand_reg(); bus.E_destM = rand_reg();
            bus.e_zf = 1'($urandom); bus.e_sf = 1'($urandom); bus.e_of = 1'($urandom);
            bus.m_stat = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(2, 4)) : 4'h1;
            bus.W_stat = ($urandom_range(0, 25) == 0) ? 4'($urandom_range(2, 4)) : 4'h1;
            settle();
            want = model_ctl();
            checks++;
            if (ctl !== want || bus.cc_cond !== model_cond(bus.E_ifun)) begin
                errors++; $display("[TB] FAIL rand_ctl[%0d] got %b/%b want %b/%b", i, ctl,
                                   bus.cc_cond, want, model_cond(bus.E_ifun));
            end
            checks++;
            if (bus.D_stall === 1'b1 && bus.D_bubble === 1'b1) begin
                errors++; $display("[TB] FAIL rand_dstall_dbubble[%0d] got 11 want not both", i);
            end
            tick();
            checks++;
            if (ccv !== m_cc || bus.halted !== m_halted || bus.halt_stat !== m_hstat ||
                int'(bus.cycle_cnt) != m_cycles || int'(bus.retire_cnt) != m_retired) begin
                errors++; $display("[TB] FAIL rand_state[%0d] got cc=%b h=%b hs=%h cnt=%0d/%0d want cc=%b h=%b hs=%h cnt=%0d/%0d",
                                   i, ccv, bus.halted, bus.halt_stat, bus.cycle_cnt, bus.retire_cnt,
                                   m_cc, m_halted, m_hstat, m_cycles, m_retired);
            end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        set_quiet();
        @(negedge clk);
        test_reset();
        test_cc_write();
        test_load_use();
        test_ret();
        test_mispredict();
        test_halt();
        test_counter_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central control for the five-stage Y86-64 pipeline.
- Owns the architectural condition-code register (ZF/SF/OF) and evaluates jXX/cmovXX conditions from it for the execute stage.
- Generates per-stage stall and bubble controls for load-use, ret and branch-mispredict hazards, and runs a halt state machine that freezes the machine on a non-AOK writeback status.
- Keeps cycle and retired-instruction counters.

Parameters:
CNT_W, 32, width of cycle_cnt and retire_cnt (wrap modulo 2^CNT_W)

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  synchronous active-low reset
D_icode  in  4  icode in decode stage
d_srcA  in  4  decode source register A (0xF = none)
d_srcB  in  4  decode source register B (0xF = none)
E_icode  in  4  icode in execute stage
E_ifun  in  4  ifun in execute stage
E_destM  in  4  memory-load destination in execute (0xF = none)
e_zf, e_sf, e_of  in  1 each  raw ALU flags for the OPq currently in execute
M_icode  in  4  icode in memory stage
m_stat  in  4  status leaving memory stage
W_icode  in  4  icode in writeback stage
W_stat  in  4  status in writeback stage
cc_zf, cc_sf, cc_of  out  1 each  registered condition codes
cc_cond  out  1  condition result for E_ifun from registered CC
set_cc  out  1  CC write enable this cycle
F_stall, D_stall, W_stall  out  1 each  hold stage register
D_bubble, E_bubble, M_bubble  out  1 each  load NOP bubble into stage register
halted  out  1  state == HALTED
halt_stat  out  4  W_stat captured at halt entry
cycle_cnt  out  CNT_W  cycles spent in RUN
retire_cnt  out  CNT_W  instructions retired

Behaviour:
- Encodings: icodes HALT=0, NOP=1, OPQ=6, JXX=7, RET=9, MRMOVQ=5, POPQ=0xB. Status AOK=1; any other value is an exception.
- Synchronous reset (rst_n=0 at an edge):
  - state <= RUN; CC <= ZF=1, SF=0, OF=0; counters <= 0; halt_stat <= 1.
  - While rst_n=0, outputs are D_bubble=E_bubble=M_bubble=1, all stalls 0, set_cc=0. This flushes the pipeline.
- cc_cond, decoded combinationally from the CC register and E_ifun:
  - 0 → 1
  - 1 (le) → (SF^OF)|ZF
  - 2 (l) → SF^OF
  - 3 (e) → ZF
  - 4 (ne) → ~ZF
  - 5 (ge) → ~(SF^OF)
  - 6 (g) → ~(SF^OF)&~ZF
  - 7..15 → 0
- Hazard terms, combinational, in RUN:
  - load_use = E_icode∈{MRMOVQ,POPQ} & E_destM≠0xF & (E_destM==d_srcA | E_destM==d_srcB)
  - ret_busy = D_icode==RET | E_icode==RET | M_icode==RET
  - mispred = E_icode==JXX & ~cc_cond
  - exc_mw = (m_stat≠AOK) | (W_stat≠AOK)
- Control outputs in RUN:
  - F_stall = load_use | ret_busy
  - D_stall = load_use
  - D_bubble = mispred | (ret_busy & ~load_use)
  - E_bubble = mispred | load_use
  - set_cc = E_icode==OPQ & ~exc_mw
  - M_bubble = exc_mw
  - W_stall = W_stat≠AOK
- Invariant: D_stall and D_bubble are never both 1.
- CC write: on the edge where set_cc=1, CC <= {e_zf,e_sf,e_of}. The new value is visible on cc_* and cc_cond the following cycle, with 1-cycle latency. With set_cc=0, CC holds.
- Halt FSM:
  - RUN → HALTED at the edge where W_stat≠AOK; halt_stat <= W_stat at that edge.
  - HALTED is left only by reset.
  - In HALTED: F_stall=D_stall=W_stall=1, all bubbles 0, set_cc=0, CC frozen.
- cycle_cnt: +1 every edge with rst_n=1 and state RUN, including the edge that enters HALTED. Wraps to 0 after all-ones.
- retire_cnt: +1 at an edge with rst_n=1, state RUN, W_stat==AOK and W_icode∉{HALT,NOP}. Bubbles never count.
- Simultaneous events:
  - mispred with RET in D: F_stall=1, D_bubble=1, E_bubble=1.
  - load_use with RET in D: F_stall=1, D_stall=1, E_bubble=1, D_bubble=0.
  - set_cc is suppressed when an exception sits in M or W in the same cycle.
  - Reset overrides HALTED and any pending transition.

Test Plan:
- Reset, then OPQ in E with e_zf=0,e_sf=1,e_of=0, all stat=1 → set_cc=1; next cycle cc=(0,1,0); E_ifun=2 gives cc_cond=1, E_ifun=6 gives 0.
- E_icode=5, E_destM=3, d_srcB=3 → F_stall=1, D_stall=1, E_bubble=1, D_bubble=0; with E_destM=0xF → all 0.
- D_icode=9 → F_stall=1, D_bubble=1; same with RET in E, then in M (3 cycles); cleared once RET reaches W.
- CC ZF=0 after reset-seeded OPQ, E_icode=7, E_ifun=3 → D_bubble=1, E_bubble=1; E_ifun=0 → no bubbles.
- OPQ in E with m_stat=3 → set_cc=0, CC unchanged, M_bubble=1; next cycle W_stat=3 → W_stall=1, halted=1, halt_stat=3, counters frozen thereafter, stalls held; rst_n=0 for 1 cycle → RUN, cc=(1,0,0), counters 0.
- CNT_W=4, 20 RUN cycles with W_icode=6, W_stat=1 → cycle_cnt=4, retire_cnt=4 (wrapped); W_icode=1 cycles leave retire_cnt unchanged.
